// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the hardwired control sequencer: opcodes, FSM states, IR field layout.
package cpu_ctrl_pkg;
    localparam int OPW      = 5;
    localparam int RSW      = 4;
    localparam int WAIT_MAX = 15;

    localparam int OP_MSB = 31;
    localparam int OP_LSB = 27;
    localparam int RA_MSB = 26;
    localparam int RA_LSB = 23;
    localparam int RB_MSB = 22;
    localparam int RB_LSB = 19;
    localparam int RC_MSB = 18;
    localparam int RC_LSB = 15;

    localparam logic [OPW-1:0] OP_ADD  = 5'b00000;
    localparam logic [OPW-1:0] OP_SUB  = 5'b00001;
    localparam logic [OPW-1:0] OP_AND  = 5'b00010;
    localparam logic [OPW-1:0] OP_OR   = 5'b00011;
    localparam logic [OPW-1:0] OP_SHR  = 5'b00100;
    localparam logic [OPW-1:0] OP_SHL  = 5'b00101;
    localparam logic [OPW-1:0] OP_ROR  = 5'b00110;
    localparam logic [OPW-1:0] OP_ROL  = 5'b00111;
    localparam logic [OPW-1:0] OP_NEG  = 5'b01000;
    localparam logic [OPW-1:0] OP_NOT  = 5'b01001;
    localparam logic [OPW-1:0] OP_MUL  = 5'b01010;
    localparam logic [OPW-1:0] OP_DIV  = 5'b01011;
    localparam logic [OPW-1:0] OP_NOP  = 5'b11000;
    localparam logic [OPW-1:0] OP_HALT = 5'b11001;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_HALT = 4'd8
    } state_t;
endpackage

// File: rtl/control_sequencer_instr_decode.sv
// Splits the IR into opcode/register fields and classifies the opcode for the sequencer.
module instr_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [31:0]    ir,
    output logic [OPW-1:0] opcode,
    output logic [RSW-1:0] ra,
    output logic [RSW-1:0] rb,
    output logic [RSW-1:0] rc,
    output logic           is_bin,
    output logic           is_unary,
    output logic           is_muldiv,
    output logic           is_nop,
    output logic           is_halt,
    output logic           is_illegal
);
    logic unused_low;

    assign opcode = ir[OP_MSB:OP_LSB];
    assign ra     = ir[RA_MSB:RA_LSB];
    assign rb     = ir[RB_MSB:RB_LSB];
    assign rc     = ir[RC_MSB:RC_LSB];
    assign unused_low = ^ir[RC_LSB-1:0];

    // ADD..ROL occupy the block whose top two opcode bits are zero
    assign is_bin     = (opcode[OPW-1:OPW-2] == 2'b00);
    assign is_unary   = (opcode == OP_NEG) || (opcode == OP_NOT);
    assign is_muldiv  = (opcode == OP_MUL) || (opcode == OP_DIV);
    assign is_nop     = (opcode == OP_NOP);
    assign is_halt    = (opcode == OP_HALT);
    assign is_illegal = !(is_bin || is_unary || is_muldiv || is_nop || is_halt);
endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch T0-T2 then per-class execute states, decoding datapath strobes from state and IR.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int WAIT_LIMIT = WAIT_MAX
) (
    input  logic           clk,
    input  logic           clr,
    input  logic           start,
    input  logic           mem_ready,
    input  logic [31:0]    ir,
    output logic           pc_out,
    output logic           mar_in,
    output logic           inc_pc,
    output logic           pc_in,
    output logic           read,
    output logic           mdr_in,
    output logic           mdr_out,
    output logic           ir_in,
    output logic           y_in,
    output logic           z_in,
    output logic           zlo_out,
    output logic           zhi_out,
    output logic           lo_in,
    output logic           hi_in,
    output logic           reg_out_en,
    output logic [RSW-1:0] reg_out_sel,
    output logic           reg_in_en,
    output logic [RSW-1:0] reg_in_sel,
    output logic [OPW-1:0] alu_op,
    output logic           instr_done,
    output logic           illegal,
    output logic           bus_err,
    output logic           halted
);
    localparam int WCW = $clog2(WAIT_LIMIT + 1);

    state_t         state, state_nxt;
    logic [WCW-1:0] wait_cnt;
    logic           timeout;

    logic [OPW-1:0] opcode;
    logic [RSW-1:0] ra, rb, rc;
    logic           is_bin, is_unary, is_muldiv, is_nop, is_halt, is_illegal;

    instr_decode u_dec (
        .ir        (ir),
        .opcode    (opcode),
        .ra        (ra),
        .rb        (rb),
        .rc        (rc),
        .is_bin    (is_bin),
        .is_unary  (is_unary),
        .is_muldiv (is_muldiv),
        .is_nop    (is_nop),
        .is_halt   (is_halt),
        .is_illegal(is_illegal)
    );

    // the cycle that would bring the count to the limit is the last one spent in T1
    assign timeout = (state == S_T1) && !mem_ready && (wait_cnt == WCW'(WAIT_LIMIT - 1));

    always_ff @(posedge clk) begin
        if (clr) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            bus_err  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_T1 && !mem_ready && !timeout)
                wait_cnt <= wait_cnt + 1'b1;
            else
                wait_cnt <= '0;
            if (timeout)
                bus_err <= 1'b1;
        end
    end

    always_comb begin
        state_nxt   = state;
        pc_out      = 1'b0;
        mar_in      = 1'b0;
        inc_pc      = 1'b0;
        pc_in       = 1'b0;
        read        = 1'b0;
        mdr_in      = 1'b0;
        mdr_out     = 1'b0;
        ir_in       = 1'b0;
        y_in        = 1'b0;
        z_in        = 1'b0;
        zlo_out     = 1'b0;
        zhi_out     = 1'b0;
        lo_in       = 1'b0;
        hi_in       = 1'b0;
        reg_out_en  = 1'b0;
        reg_out_sel = '0;
        reg_in_en   = 1'b0;
        reg_in_sel  = '0;
        alu_op      = '0;
        instr_done  = 1'b0;
        illegal     = 1'b0;
        halted      = 1'b0;
        case (state)
            S_IDLE, S_HALT: begin
                halted = 1'b1;
                if (start) state_nxt = S_T0;
            end
            S_T0: begin
                pc_out    = 1'b1;
                mar_in    = 1'b1;
                inc_pc    = 1'b1;
                state_nxt = S_T1;
            end
            S_T1: begin
                read   = 1'b1;
                mdr_in = 1'b1;
                if (mem_ready) begin
                    pc_in     = 1'b1;
                    state_nxt = S_T2;
                end else if (timeout) begin
                    state_nxt = S_HALT;
                end
            end
            S_T2: begin
                mdr_out   = 1'b1;
                ir_in     = 1'b1;
                state_nxt = S_T3;
            end
            S_T3: begin
                if (is_bin || is_muldiv) begin
                    reg_out_en  = 1'b1;
                    reg_out_sel = is_bin ? rb : ra;
                    y_in        = 1'b1;
                    state_nxt   = S_T4;
                end else if (is_unary) begin
                    state_nxt = S_T4;
                end else begin
                    instr_done = 1'b1;
                    illegal    = is_illegal;
                    state_nxt  = is_halt ? S_HALT : S_T0;
                end
            end
            S_T4: begin
                reg_out_en  = 1'b1;
                reg_out_sel = is_bin ? rc : rb;
                alu_op      = opcode;
                z_in        = 1'b1;
                state_nxt   = S_T5;
            end
            S_T5: begin
                zlo_out = 1'b1;
                if (is_muldiv) begin
                    lo_in     = 1'b1;
                    state_nxt = S_T6;
                end else begin
                    reg_in_en  = 1'b1;
                    reg_in_sel = ra;
                    instr_done = 1'b1;
                    state_nxt  = S_T0;
                end
            end
            S_T6: begin
                zhi_out    = 1'b1;
                hi_in      = 1'b1;
                instr_done = 1'b1;
                state_nxt  = S_T0;
            end
            default: state_nxt = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: instruction-level strobe model plus a tiny datapath driven by the DUT strobes.
module tb_control_sequencer;
    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        start = 1'b0;
    logic        mem_ready = 1'b1;
    logic [31:0] ir = 32'h0;
    logic        pc_out, mar_in, inc_pc, pc_in, read, mdr_in, mdr_out, ir_in;
    logic        y_in, z_in, zlo_out, zhi_out, lo_in, hi_in;
    logic        reg_out_en, reg_in_en, instr_done, illegal, bus_err, halted;
    logic [3:0]  reg_out_sel, reg_in_sel;
    logic [4:0]  alu_op;

    control_sequencer dut (
        .clk(clk), .clr(clr), .start(start), .mem_ready(mem_ready), .ir(ir),
        .pc_out(pc_out), .mar_in(mar_in), .inc_pc(inc_pc), .pc_in(pc_in),
        .read(read), .mdr_in(mdr_in), .mdr_out(mdr_out), .ir_in(ir_in),
        .y_in(y_in), .z_in(z_in), .zlo_out(zlo_out), .zhi_out(zhi_out),
        .lo_in(lo_in), .hi_in(hi_in),
        .reg_out_en(reg_out_en), .reg_out_sel(reg_out_sel),
        .reg_in_en(reg_in_en), .reg_in_sel(reg_in_sel), .alu_op(alu_op),
        .instr_done(instr_done), .illegal(illegal), .bus_err(bus_err), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic pc_out, mar_in, inc_pc, pc_in, read, mdr_in, mdr_out, ir_in;
        logic y_in, z_in, zlo_out, zhi_out, lo_in, hi_in, reg_out_en;
        logic [3:0] reg_out_sel;
        logic reg_in_en;
        logic [3:0] reg_in_sel;
        logic [4:0] alu_op;
        logic instr_done, illegal, bus_err, halted;
        logic t1, stop;
    } ow_t;

    int errors = 0;
    int checks = 0;

    // model: a queue of the cycles the current instruction still has to run
    ow_t q[$];
    bit  m_on = 0;
    bit  m_buserr = 0;
    int  m_wait = 0;

    logic [31:0] R [16];
    logic [31:0] Y = 0, LO = 0, HI = 0;
    logic [63:0] Z = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic load_fetch();
        ow_t w;
        m_wait = 0;
        w = '0; w.pc_out = 1; w.mar_in = 1; w.inc_pc = 1; q.push_back(w);
        w = '0; w.read = 1; w.mdr_in = 1; w.t1 = 1;       q.push_back(w);
        w = '0; w.mdr_out = 1; w.ir_in = 1;               q.push_back(w);
    endtask

    task automatic load_exec(input logic [31:0] iw);
        ow_t w;
        logic [4:0] op;
        logic [3:0] ra, rb, rc;
        op = iw[31:27]; ra = iw[26:23]; rb = iw[22:19]; rc = iw[18:15];
        if (op <= 5'd7) begin
            w = '0; w.reg_out_en = 1; w.reg_out_sel = rb; w.y_in = 1; q.push_back(w);
            w = '0; w.reg_out_en = 1; w.reg_out_sel = rc; w.alu_op = op; w.z_in = 1; q.push_back(w);
            w = '0; w.zlo_out = 1; w.reg_in_en = 1; w.reg_in_sel = ra; w.instr_done = 1; q.push_back(w);
        end else if (op == 5'd8 || op == 5'd9) begin
            w = '0; q.push_back(w);
            w = '0; w.reg_out_en = 1; w.reg_out_sel = rb; w.alu_op = op; w.z_in = 1; q.push_back(w);
            w = '0; w.zlo_out = 1; w.reg_in_en = 1; w.reg_in_sel = ra; w.instr_done = 1; q.push_back(w);
        end else if (op == 5'd10 || op == 5'd11) begin
            w = '0; w.reg_out_en = 1; w.reg_out_sel = ra; w.y_in = 1; q.push_back(w);
            w = '0; w.reg_out_en = 1; w.reg_out_sel = rb; w.alu_op = op; w.z_in = 1; q.push_back(w);
            w = '0; w.zlo_out = 1; w.lo_in = 1; q.push_back(w);
            w = '0; w.zhi_out = 1; w.hi_in = 1; w.instr_done = 1; q.push_back(w);
        end else if (op == 5'b11000) begin
            w = '0; w.instr_done = 1; q.push_back(w);
        end else if (op == 5'b11001) begin
            w = '0; w.instr_done = 1; w.stop = 1; q.push_back(w);
        end else begin
            w = '0; w.illegal = 1; w.instr_done = 1; q.push_back(w);
        end
    endtask

    function automatic logic [63:0] alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            5'd0:    return {32'h0, a + b};
            5'd1:    return {32'h0, a - b};
            5'd8:    return {32'h0, -b};
            5'd9:    return {32'h0, ~b};
            5'd10:   return $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            default: return 64'h0;
        endcase
    endfunction

    // compare, then let the datapath and the model take the coming edge
    always @(negedge clk) begin
        ow_t exp, act;
        ow_t cur;
        logic [31:0] bus;
        exp = '0;
        if (m_on && q.size() > 0) begin
            exp = q[0];
            if (exp.t1) exp.pc_in = mem_ready;
        end
        exp.t1 = 0; exp.stop = 0;
        exp.bus_err = m_buserr;
        exp.halted = !m_on;
        act = {pc_out, mar_in, inc_pc, pc_in, read, mdr_in, mdr_out, ir_in,
               y_in, z_in, zlo_out, zhi_out, lo_in, hi_in, reg_out_en, reg_out_sel,
               reg_in_en, reg_in_sel, alu_op, instr_done, illegal, bus_err, halted, 2'b00};
        chk("strobes", 64'(act), 64'(exp));
        checks++;
        if (!$onehot0({pc_out, mdr_out, reg_out_en, zlo_out, zhi_out})) begin
            errors++;
            $display("FAIL bus_drivers: got %b expected at most one", {pc_out, mdr_out, reg_out_en, zlo_out, zhi_out});
        end

        bus = reg_out_en ? R[reg_out_sel] : zlo_out ? Z[31:0] : zhi_out ? Z[63:32] : 32'h0;
        if (z_in) Z = alu(alu_op, Y, bus);
        if (y_in) Y = bus;
        if (reg_in_en) R[reg_in_sel] = bus;
        if (lo_in) LO = bus;
        if (hi_in) HI = bus;

        if (clr) begin
            m_on = 0; m_buserr = 0; m_wait = 0; q.delete();
        end else if (!m_on) begin
            if (start) begin m_on = 1; load_fetch(); end
        end else if (q[0].t1) begin
            if (mem_ready) begin
                cur = q.pop_front();
                m_wait = 0;
            end else begin
                m_wait++;
                if (m_wait == 15) begin m_on = 0; m_buserr = 1; q.delete(); end
            end
        end else begin
            cur = q.pop_front();
            if (cur.ir_in) load_exec(ir);
            else if (q.size() == 0) begin
                if (cur.stop) m_on = 0;
                else load_fetch();
            end
        end
    end

    task automatic tick();
        @(posedge clk); #2;
    endtask

    // k counts cycles from the first state after the start pulse (k=1 is T0)
    task automatic run_instr(input bit do_start, input int low, input int start_at, input int clr_at,
                             input int maxc, output int n, output bit saw_rin, output bit ill_done);
        n = 0; saw_rin = 0; ill_done = 0;
        if (do_start) begin
            start = 1; mem_ready = 1; tick(); start = 0;
        end
        for (int k = 1; k <= maxc; k++) begin
            mem_ready = !(k >= 2 && k < 2 + low);
            start = (k == start_at);
            clr = (k == clr_at);
            @(negedge clk);
            if (reg_in_en) saw_rin = 1;
            if (instr_done) begin
                n = k;
                ill_done = illegal;
                break;
            end
            if (k < maxc) tick();
        end
        start = 0; clr = 0; mem_ready = 1;
        tick();
    endtask

    initial begin
        int  n;
        bit  rin, ild;
        for (int i = 0; i < 16; i++) R[i] = 32'h0;
        R[4] = 32'd10; R[5] = 32'd2;
        clr = 1; tick(); tick();
        @(negedge clk);
        chk("reset_halted", 64'(halted), 64'd1);
        chk("reset_bus_err", 64'(bus_err), 64'd0);
        tick(); clr = 0; tick();

        ir = 32'h0022_8000;
        run_instr(1, 0, 0, 0, 20, n, rin, ild);
        chk("add_latency", 64'(n), 64'd6);
        chk("add_r0", 64'(R[0]), 64'd12);
        clr = 1; tick(); clr = 0;

        R[0] = 32'h0;
        run_instr(1, 3, 0, 0, 20, n, rin, ild);
        chk("wait3_latency", 64'(n), 64'd9);
        chk("wait3_r0", 64'(R[0]), 64'd12);
        clr = 1; tick(); clr = 0;

        R[3] = 32'h0001_0000; R[4] = 32'h0001_0000;
        ir = 32'h51A0_0000;
        run_instr(1, 0, 0, 0, 20, n, rin, ild);
        chk("mul_latency", 64'(n), 64'd7);
        chk("mul_lo", 64'(LO), 64'd0);
        chk("mul_hi", 64'(HI), 64'd1);
        clr = 1; tick(); clr = 0;

        ir = 32'hF800_0000;
        run_instr(1, 0, 0, 0, 20, n, rin, ild);
        chk("illegal_latency", 64'(n), 64'd4);
        chk("illegal_with_done", 64'(ild), 64'd1);
        ir = 32'hC800_0000;
        run_instr(0, 0, 2, 0, 20, n, rin, ild);
        chk("halt_latency", 64'(n), 64'd4);
        @(negedge clk);
        chk("halt_halted", 64'(halted), 64'd1);
        tick();

        ir = 32'h0022_8000;
        run_instr(1, 1000, 0, 0, 20, n, rin, ild);
        chk("timeout_no_done", 64'(n), 64'd0);
        @(negedge clk);
        chk("timeout_halted", 64'(halted), 64'd1);
        chk("timeout_bus_err", 64'(bus_err), 64'd1);
        tick();
        ir = 32'hC000_0000;
        run_instr(1, 0, 0, 0, 20, n, rin, ild);
        chk("refetch_nop_latency", 64'(n), 64'd4);
        chk("refetch_bus_err_sticky", 64'(bus_err), 64'd1);
        clr = 1; tick(); clr = 0;
        @(negedge clk);
        chk("clr_bus_err", 64'(bus_err), 64'd0);
        tick();

        R[0] = 32'h0;
        ir = 32'h0022_8000;
        run_instr(1, 0, 0, 5, 10, n, rin, ild);
        chk("abort_no_done", 64'(n), 64'd0);
        chk("abort_no_reg_in", 64'(rin), 64'd0);
        chk("abort_r0_kept", 64'(R[0]), 64'd0);
        @(negedge clk);
        chk("abort_halted", 64'(halted), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
